// File: rtl/wb4_to_pi1.sv
// Wishbone B4 pipelined slave to PI1 master bridge with a single outstanding access.
// Each accepted WB request becomes one PI1 operation; completion returns as a one-cycle ack.
module wb4_to_pi1 #(
   parameter  int ARCHBITSZ = 16,
   localparam int SELW      = ARCHBITSZ / 8,
   localparam int LSB       = $clog2(SELW),
   localparam int ADDRBITSZ = ARCHBITSZ - LSB
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wb4_cyc_i,
   input  logic                 wb4_stb_i,
   input  logic                 wb4_we_i,
   input  logic [ARCHBITSZ-1:0] wb4_addr_i,
   input  logic [SELW-1:0]      wb4_sel_i,
   input  logic [ARCHBITSZ-1:0] wb4_data_i,
   output logic                 wb4_stall_o,
   output logic                 wb4_ack_o,
   output logic [ARCHBITSZ-1:0] wb4_data_o,
   output logic [1:0]           pi1_op_o,
   output logic [ADDRBITSZ-1:0] pi1_addr_o,
   output logic [SELW-1:0]      pi1_sel_o,
   output logic [ARCHBITSZ-1:0] pi1_data_o,
   input  logic [ARCHBITSZ-1:0] pi1_data_i,
   input  logic                 pi1_rdy_i
);

   localparam logic [1:0] OP_NOOP = 2'd0;
   localparam logic [1:0] OP_WR   = 2'd1;
   localparam logic [1:0] OP_RD   = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t state;
   logic   we_q;
   logic   null_op;
   logic   abort;
   logic   abort_n;
   logic   unused_addr_lsb;

   // Abort is sticky from the first cycle the master drops cyc during ISSUE/WAIT.
   assign abort_n         = abort | ~wb4_cyc_i;
   assign unused_addr_lsb = ^wb4_addr_i[LSB-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         we_q        <= 1'b0;
         null_op     <= 1'b0;
         abort       <= 1'b0;
         wb4_stall_o <= 1'b0;
         wb4_ack_o   <= 1'b0;
         wb4_data_o  <= '0;
         pi1_op_o    <= OP_NOOP;
         pi1_addr_o  <= '0;
         pi1_sel_o   <= '0;
         pi1_data_o  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               wb4_ack_o <= 1'b0;
               if (wb4_cyc_i && wb4_stb_i) begin
                  we_q        <= wb4_we_i;
                  pi1_addr_o  <= wb4_addr_i[ARCHBITSZ-1:LSB];
                  pi1_sel_o   <= wb4_sel_i;
                  pi1_data_o  <= wb4_data_i;
                  abort       <= 1'b0;
                  wb4_stall_o <= 1'b1;
                  state       <= S_ISSUE;
                  // A write touching no byte lanes needs no PI1 traffic at all.
                  if (wb4_we_i && wb4_sel_i == '0) begin
                     null_op  <= 1'b1;
                     pi1_op_o <= OP_NOOP;
                  end else begin
                     null_op  <= 1'b0;
                     pi1_op_o <= wb4_we_i ? OP_WR : OP_RD;
                  end
               end
            end
            S_ISSUE: begin
               abort <= abort_n;
               if (null_op) begin
                  if (!wb4_cyc_i) begin
                     abort       <= 1'b0;
                     wb4_stall_o <= 1'b0;
                     state       <= S_IDLE;
                  end else begin
                     wb4_ack_o <= 1'b1;
                     state     <= S_RESP;
                  end
               end else if (pi1_rdy_i) begin
                  pi1_op_o <= OP_NOOP;
                  state    <= S_WAIT;
               end else if (!wb4_cyc_i) begin
                  // Op not yet taken by the slave: withdraw it.
                  pi1_op_o    <= OP_NOOP;
                  abort       <= 1'b0;
                  wb4_stall_o <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            S_WAIT: begin
               abort <= abort_n;
               if (pi1_rdy_i) begin
                  if (!we_q) wb4_data_o <= pi1_data_i;
                  wb4_ack_o <= ~abort_n;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               wb4_ack_o   <= 1'b0;
               abort       <= 1'b0;
               wb4_stall_o <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb4_to_pi1.sv
// Directed bench for wb4_to_pi1: reset, read, stalled write, back-to-back, zero-sel,
// abort paths and reset mid-access, with hand-computed expectations.
module tb_wb4_to_pi1;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        wb4_cyc_i = 1'b0;
   logic        wb4_stb_i = 1'b0;
   logic        wb4_we_i = 1'b0;
   logic [15:0] wb4_addr_i = '0;
   logic [1:0]  wb4_sel_i = '0;
   logic [15:0] wb4_data_i = '0;
   logic        wb4_stall_o;
   logic        wb4_ack_o;
   logic [15:0] wb4_data_o;
   logic [1:0]  pi1_op_o;
   logic [14:0] pi1_addr_o;
   logic [1:0]  pi1_sel_o;
   logic [15:0] pi1_data_o;
   logic [15:0] pi1_data_i = '0;
   logic        pi1_rdy_i = 1'b0;

   int tests_run = 0;
   int fails = 0;
   int ack_cnt = 0;
   int op_cycles = 0;
   int op_starts = 0;
   logic [1:0] prev_op = 2'd0;

   wb4_to_pi1 #(.ARCHBITSZ(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .wb4_cyc_i(wb4_cyc_i), .wb4_stb_i(wb4_stb_i), .wb4_we_i(wb4_we_i),
      .wb4_addr_i(wb4_addr_i), .wb4_sel_i(wb4_sel_i), .wb4_data_i(wb4_data_i),
      .wb4_stall_o(wb4_stall_o), .wb4_ack_o(wb4_ack_o), .wb4_data_o(wb4_data_o),
      .pi1_op_o(pi1_op_o), .pi1_addr_o(pi1_addr_o), .pi1_sel_o(pi1_sel_o),
      .pi1_data_o(pi1_data_o), .pi1_data_i(pi1_data_i), .pi1_rdy_i(pi1_rdy_i)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   // Event counters sampled mid-cycle; tests compare deltas across a scenario.
   always @(negedge clk_i) begin
      if (wb4_ack_o === 1'b1) ack_cnt <= ack_cnt + 1;
      if (pi1_op_o !== 2'd0 && !$isunknown(pi1_op_o)) op_cycles <= op_cycles + 1;
      if (pi1_op_o !== 2'd0 && !$isunknown(pi1_op_o) && prev_op == 2'd0) op_starts <= op_starts + 1;
      prev_op <= $isunknown(pi1_op_o) ? 2'd0 : pi1_op_o;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [15:0] addr, input logic [1:0] sel,
                            input logic [15:0] data);
      wb4_cyc_i  = 1'b1;
      wb4_stb_i  = 1'b1;
      wb4_we_i   = we;
      wb4_addr_i = addr;
      wb4_sel_i  = sel;
      wb4_data_i = data;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      tests_run++; if (wb4_stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall got %0h want 0", wb4_stall_o); end
      tests_run++; if (wb4_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack got %0h want 0", wb4_ack_o); end
      tests_run++; if (wb4_data_o !== 16'h0) begin fails++; $display("FAIL reset_rdata got %0h want 0", wb4_data_o); end
      tests_run++; if (pi1_op_o !== 2'd0) begin fails++; $display("FAIL reset_op got %0h want 0", pi1_op_o); end
      tests_run++; if (pi1_addr_o !== 15'h0 || pi1_sel_o !== 2'b00 || pi1_data_o !== 16'h0) begin
         fails++; $display("FAIL reset_pi1_fields got %0h/%0h/%0h want 0/0/0", pi1_addr_o, pi1_sel_o, pi1_data_o); end
   endtask

   task automatic test_read();
      int n;
      int a0;
      a0 = ack_cnt;
      pi1_rdy_i  = 1'b1;
      pi1_data_i = 16'h1234;
      drive_req(1'b0, 16'h0014, 2'b11, 16'h0);
      tick();
      wb4_stb_i = 1'b0;
      n = 1;
      tests_run++; if (pi1_op_o !== 2'd2) begin fails++; $display("FAIL read_op got %0h want 2", pi1_op_o); end
      tests_run++; if (pi1_addr_o !== 15'h000A) begin fails++; $display("FAIL read_addr got %0h want a", pi1_addr_o); end
      tests_run++; if (pi1_sel_o !== 2'b11) begin fails++; $display("FAIL read_sel got %0h want 3", pi1_sel_o); end
      tests_run++; if (wb4_stall_o !== 1'b1) begin fails++; $display("FAIL read_stall got %0h want 1", wb4_stall_o); end
      while (wb4_ack_o !== 1'b1 && n < 12) begin tick(); n++; end
      tests_run++; if (n != 3) begin fails++; $display("FAIL read_latency got %0d want 3", n); end
      tests_run++; if (wb4_data_o !== 16'h1234) begin fails++; $display("FAIL read_data got %0h want 1234", wb4_data_o); end
      wb4_cyc_i = 1'b0;
      tick();
      tests_run++; if (wb4_ack_o !== 1'b0 || wb4_stall_o !== 1'b0) begin
         fails++; $display("FAIL read_after ack/stall got %0h/%0h want 0/0", wb4_ack_o, wb4_stall_o); end
      tick();
      tests_run++; if (ack_cnt - a0 != 1) begin fails++; $display("FAIL read_ack_count got %0d want 1", ack_cnt - a0); end
   endtask

   task automatic test_write_stalled();
      int a0;
      int c0;
      int bad;
      a0 = ack_cnt;
      c0 = op_cycles;
      bad = 0;
      pi1_rdy_i  = 1'b0;
      pi1_data_i = 16'hFFFF;
      drive_req(1'b1, 16'h0020, 2'b01, 16'hA5A5);
      tick();
      wb4_stb_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (pi1_op_o !== 2'd1 || wb4_stall_o !== 1'b1 || wb4_ack_o !== 1'b0) bad++;
         if (i == 4) pi1_rdy_i = 1'b1;
         tick();
      end
      tests_run++; if (bad != 0) begin fails++; $display("FAIL wr_hold bad_cycles got %0d want 0", bad); end
      tests_run++; if (pi1_data_o !== 16'hA5A5 || pi1_sel_o !== 2'b01 || pi1_addr_o !== 15'h0010) begin
         fails++; $display("FAIL wr_fields got %0h/%0h/%0h want a5a5/1/10", pi1_data_o, pi1_sel_o, pi1_addr_o); end
      tests_run++; if (pi1_op_o !== 2'd0 || wb4_stall_o !== 1'b1) begin
         fails++; $display("FAIL wr_wait op/stall got %0h/%0h want 0/1", pi1_op_o, wb4_stall_o); end
      tick();
      tests_run++; if (wb4_ack_o !== 1'b1) begin fails++; $display("FAIL wr_ack got %0h want 1", wb4_ack_o); end
      tests_run++; if (wb4_data_o !== 16'h1234) begin fails++; $display("FAIL wr_keeps_rdata got %0h want 1234", wb4_data_o); end
      wb4_cyc_i = 1'b0;
      tick();
      tick();
      tests_run++; if (ack_cnt - a0 != 1) begin fails++; $display("FAIL wr_ack_count got %0d want 1", ack_cnt - a0); end
      tests_run++; if (op_cycles - c0 != 5) begin fails++; $display("FAIL wr_op_cycles got %0d want 5", op_cycles - c0); end
   endtask

   task automatic test_back_to_back();
      int a0;
      int s0;
      a0 = ack_cnt;
      s0 = op_starts;
      pi1_rdy_i  = 1'b1;
      pi1_data_i = 16'hBEEF;
      drive_req(1'b0, 16'h0040, 2'b11, 16'h0);
      tick();
      tick();
      tick();
      tests_run++; if (wb4_ack_o !== 1'b1 || wb4_data_o !== 16'hBEEF) begin
         fails++; $display("FAIL b2b_first ack/data got %0h/%0h want 1/beef", wb4_ack_o, wb4_data_o); end
      tick();
      tests_run++; if (wb4_stall_o !== 1'b0 || wb4_ack_o !== 1'b0) begin
         fails++; $display("FAIL b2b_idle stall/ack got %0h/%0h want 0/0", wb4_stall_o, wb4_ack_o); end
      wb4_addr_i = 16'h0042;
      pi1_data_i = 16'hCAFE;
      tick();
      wb4_stb_i = 1'b0;
      tests_run++; if (pi1_op_o !== 2'd2 || pi1_addr_o !== 15'h0021 || wb4_stall_o !== 1'b1) begin
         fails++; $display("FAIL b2b_second op/addr/stall got %0h/%0h/%0h want 2/21/1", pi1_op_o, pi1_addr_o, wb4_stall_o); end
      tick();
      tick();
      tests_run++; if (wb4_ack_o !== 1'b1 || wb4_data_o !== 16'hCAFE) begin
         fails++; $display("FAIL b2b_second_ack ack/data got %0h/%0h want 1/cafe", wb4_ack_o, wb4_data_o); end
      wb4_cyc_i = 1'b0;
      tick();
      tick();
      tick();
      tests_run++; if (ack_cnt - a0 != 2) begin fails++; $display("FAIL b2b_acks got %0d want 2", ack_cnt - a0); end
      tests_run++; if (op_starts - s0 != 2) begin fails++; $display("FAIL b2b_ops got %0d want 2", op_starts - s0); end
   endtask

   task automatic test_zero_sel_write();
      int c0;
      int a0;
      c0 = op_cycles;
      a0 = ack_cnt;
      pi1_rdy_i = 1'b1;
      drive_req(1'b1, 16'h0060, 2'b00, 16'h1111);
      tick();
      wb4_stb_i = 1'b0;
      tests_run++; if (pi1_op_o !== 2'd0 || wb4_stall_o !== 1'b1 || wb4_ack_o !== 1'b0) begin
         fails++; $display("FAIL zsel_issue op/stall/ack got %0h/%0h/%0h want 0/1/0", pi1_op_o, wb4_stall_o, wb4_ack_o); end
      tick();
      tests_run++; if (wb4_ack_o !== 1'b1) begin fails++; $display("FAIL zsel_ack got %0h want 1", wb4_ack_o); end
      wb4_cyc_i = 1'b0;
      tick();
      tests_run++; if (wb4_ack_o !== 1'b0 || wb4_stall_o !== 1'b0) begin
         fails++; $display("FAIL zsel_after ack/stall got %0h/%0h want 0/0", wb4_ack_o, wb4_stall_o); end
      tick();
      tests_run++; if (op_cycles - c0 != 0 || ack_cnt - a0 != 1) begin
         fails++; $display("FAIL zsel_counts ops/acks got %0d/%0d want 0/1", op_cycles - c0, ack_cnt - a0); end
   endtask

   task automatic test_abort();
      int a0;
      int n;
      a0 = ack_cnt;
      pi1_rdy_i = 1'b0;
      drive_req(1'b0, 16'h0080, 2'b11, 16'h0);
      tick();
      tests_run++; if (pi1_op_o !== 2'd2) begin fails++; $display("FAIL abort_issue_op got %0h want 2", pi1_op_o); end
      wb4_stb_i = 1'b0;
      wb4_cyc_i = 1'b0;
      tick();
      tests_run++; if (pi1_op_o !== 2'd0 || wb4_stall_o !== 1'b0) begin
         fails++; $display("FAIL abort_issue_withdraw op/stall got %0h/%0h want 0/0", pi1_op_o, wb4_stall_o); end
      tick();
      tick();
      tests_run++; if (ack_cnt - a0 != 0) begin fails++; $display("FAIL abort_issue_acks got %0d want 0", ack_cnt - a0); end

      pi1_rdy_i  = 1'b1;
      pi1_data_i = 16'h5A5A;
      drive_req(1'b0, 16'h0090, 2'b11, 16'h0);
      tick();
      wb4_stb_i = 1'b0;
      tick();
      tests_run++; if (pi1_op_o !== 2'd0 || wb4_stall_o !== 1'b1) begin
         fails++; $display("FAIL abort_wait_entry op/stall got %0h/%0h want 0/1", pi1_op_o, wb4_stall_o); end
      wb4_cyc_i = 1'b0;
      pi1_rdy_i = 1'b0;
      tick();
      tests_run++; if (wb4_stall_o !== 1'b1) begin fails++; $display("FAIL abort_wait_hold got %0h want 1", wb4_stall_o); end
      pi1_rdy_i = 1'b1;
      tick();
      tests_run++; if (wb4_ack_o !== 1'b0 || wb4_data_o !== 16'h5A5A) begin
         fails++; $display("FAIL abort_wait_resp ack/data got %0h/%0h want 0/5a5a", wb4_ack_o, wb4_data_o); end
      tick();
      tests_run++; if (wb4_stall_o !== 1'b0 || ack_cnt - a0 != 0) begin
         fails++; $display("FAIL abort_wait_done stall/acks got %0h/%0d want 0/0", wb4_stall_o, ack_cnt - a0); end

      pi1_data_i = 16'h7777;
      drive_req(1'b0, 16'h00A0, 2'b11, 16'h0);
      tick();
      wb4_stb_i = 1'b0;
      n = 1;
      while (wb4_ack_o !== 1'b1 && n < 12) begin tick(); n++; end
      tests_run++; if (n != 3 || wb4_data_o !== 16'h7777) begin
         fails++; $display("FAIL abort_next_req latency/data got %0d/%0h want 3/7777", n, wb4_data_o); end
      wb4_cyc_i = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_in_wait();
      int a0;
      pi1_rdy_i = 1'b1;
      drive_req(1'b1, 16'h00C0, 2'b11, 16'h3333);
      tick();
      wb4_stb_i = 1'b0;
      tick();
      pi1_rdy_i = 1'b0;
      a0 = ack_cnt;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      tests_run++; if (wb4_stall_o !== 1'b0 || wb4_ack_o !== 1'b0 || pi1_op_o !== 2'd0) begin
         fails++; $display("FAIL rst_wait stall/ack/op got %0h/%0h/%0h want 0/0/0", wb4_stall_o, wb4_ack_o, pi1_op_o); end
      tests_run++; if (wb4_data_o !== 16'h0 || pi1_addr_o !== 15'h0 || pi1_sel_o !== 2'b00 || pi1_data_o !== 16'h0) begin
         fails++; $display("FAIL rst_wait_fields got %0h/%0h/%0h/%0h want 0/0/0/0", wb4_data_o, pi1_addr_o, pi1_sel_o, pi1_data_o); end
      wb4_cyc_i = 1'b0;
      pi1_rdy_i = 1'b1;
      tick();
      tick();
      tick();
      tests_run++; if (ack_cnt - a0 != 0 || wb4_stall_o !== 1'b0) begin
         fails++; $display("FAIL rst_wait_after acks/stall got %0d/%0h want 0/0", ack_cnt - a0, wb4_stall_o); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_stalled();
      test_back_to_back();
      test_zero_sel_write();
      test_abort();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
